ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter; the send-side counterpart of the Ps2Input receiver.
- Sends one command byte to the keyboard (e.g. 0xED LED set, 0xFF reset) over the shared open-drain PS/2 clock/data lines.
- Sits beside Ps2Input on the same clock; its oBusy output gates the receiver while a frame is in flight.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_line_sync.sv | 35 +++
 rtl/ps2_host_tx.sv | 196 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and its line conditioning.
// Holds the transmitter state encoding, the error codes and the frame length.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } ps2State_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NOACK   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Bits the host drives after the start bit: 8 data, parity, stop.
    localparam int FRAME_BITS = 10;

    function automatic logic oddParity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS/2 clock/data pads plus a registered
// falling-edge pulse on the clock; pad-to-pulse latency is three iClk cycles.
module ps2_line_sync (
    input  logic iClk,
    input  logic iReset_n,
    input  logic iPs2_Clk,
    input  logic iPs2_Data,
    output logic oClkSync,
    output logic oDataSync,
    output logic oFallPulse
);

    logic [1:0] clkMeta;
    logic [1:0] dataMeta;
    logic       clkDly;

    // Reset to the idle-high line level so release from reset never fakes an edge.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            clkMeta    <= 2'b11;
            dataMeta   <= 2'b11;
            clkDly     <= 1'b1;
            oFallPulse <= 1'b0;
        end else begin
            clkMeta    <= {clkMeta[0], iPs2_Clk};
            dataMeta   <= {dataMeta[0], iPs2_Data};
            clkDly     <= clkMeta[1];
            oFallPulse <= clkDly & ~clkMeta[1];
        end
    end

    assign oClkSync  = clkMeta[1];
    assign oDataSync = dataMeta[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain clock/data enables.
// Define PS2_TX_RETRY_EN to retry failed frames up to MAX_RETRIES times before reporting.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int SETUP_CYCLES   = 500,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int MAX_RETRIES    = 2
) (
    input  logic       iClk,
    input  logic       iReset_n,
    input  logic       iStart,
    input  logic [7:0] iData,
    input  logic       iPs2_Clk,
    input  logic       iPs2_Data,
    output logic       oPs2_Clk_Oe,
    output logic       oPs2_Data_Oe,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError,
    output logic [1:0] oErrCode
);

    localparam int TMR_W = $clog2(INHIBIT_CYCLES > SETUP_CYCLES ? INHIBIT_CYCLES : SETUP_CYCLES);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] INHIBIT_LOAD = TMR_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETUP_LOAD   = TMR_W'(SETUP_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LOAD      = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_IDX     = 4'(FRAME_BITS - 1);

    logic clkSync, dataSync, fallPulse;

    ps2_line_sync uLineSync (
        .iClk      (iClk),
        .iReset_n  (iReset_n),
        .iPs2_Clk  (iPs2_Clk),
        .iPs2_Data (iPs2_Data),
        .oClkSync  (clkSync),
        .oDataSync (dataSync),
        .oFallPulse(fallPulse)
    );

    ps2State_t        state, stateNext;
    logic [TMR_W-1:0] timer, timerNext;
    logic [WD_W-1:0]  wdog, wdogNext;
    logic [3:0]       bitIdx, bitIdxNext;
    logic [8:0]       txFrame, txFrameNext;
    logic             dataOe, dataOeNext;
    logic [1:0]       errCode, errCodeNext;
    logic             fail;
    logic [1:0]       failCode;
    logic             wdExpired;
    logic [FRAME_BITS-1:0] frameBits;

`ifdef PS2_TX_RETRY_EN
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    logic [RETRY_W-1:0] retryCnt, retryNext;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) retryCnt <= '0;
        else           retryCnt <= retryNext;
    end
`endif

    assign frameBits = {1'b1, txFrame};
    assign wdExpired = (wdog == '0);

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state   <= IDLE;
            timer   <= '0;
            wdog    <= '0;
            bitIdx  <= '0;
            txFrame <= '0;
            dataOe  <= 1'b0;
            errCode <= ERR_NONE;
        end else begin
            state   <= stateNext;
            timer   <= timerNext;
            wdog    <= wdogNext;
            bitIdx  <= bitIdxNext;
            txFrame <= txFrameNext;
            dataOe  <= dataOeNext;
            errCode <= errCodeNext;
        end
    end

    always_comb begin
        stateNext   = state;
        timerNext   = timer;
        wdogNext    = wdog;
        bitIdxNext  = bitIdx;
        txFrameNext = txFrame;
        dataOeNext  = dataOe;
        errCodeNext = errCode;
        fail        = 1'b0;
        failCode    = ERR_NONE;
`ifdef PS2_TX_RETRY_EN
        retryNext   = retryCnt;
`endif

        if (state inside {SEND, ACK, WAIT_IDLE})
            wdogNext = fallPulse ? WD_LOAD : wdog - WD_W'(1);

        unique case (state)
            IDLE: begin
                if (iStart) begin
                    txFrameNext = {oddParity(iData), iData};
                    errCodeNext = ERR_NONE;
                    timerNext   = INHIBIT_LOAD;
                    dataOeNext  = 1'b0;
                    stateNext   = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retryNext   = '0;
`endif
                end
            end
            INHIBIT: begin
                if (timer == '0) begin
                    timerNext  = SETUP_LOAD;
                    dataOeNext = 1'b1;
                    stateNext  = RTS;
                end else begin
                    timerNext = timer - TMR_W'(1);
                end
            end
            RTS: begin
                if (timer == '0) begin
                    wdogNext   = WD_LOAD;
                    bitIdxNext = '0;
                    stateNext  = SEND;
                end else begin
                    timerNext = timer - TMR_W'(1);
                end
            end
            SEND: begin
                if (wdExpired) begin
                    fail     = 1'b1;
                    failCode = ERR_TIMEOUT;
                end else if (fallPulse) begin
                    dataOeNext = ~frameBits[bitIdx];
                    bitIdxNext = bitIdx + 4'd1;
                    if (bitIdx == LAST_IDX) stateNext = ACK;
                end
            end
            ACK: begin
                if (wdExpired) begin
                    fail     = 1'b1;
                    failCode = ERR_TIMEOUT;
                end else if (fallPulse) begin
                    if (dataSync) begin
                        fail     = 1'b1;
                        failCode = ERR_NOACK;
                    end else begin
                        stateNext = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (wdExpired) begin
                    fail     = 1'b1;
                    failCode = ERR_TIMEOUT;
                end else if (clkSync && dataSync) begin
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            ERR:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        if (fail) begin
            dataOeNext = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (retryCnt < RETRY_W'(MAX_RETRIES)) begin
                retryNext = retryCnt + RETRY_W'(1);
                timerNext = INHIBIT_LOAD;
                stateNext = INHIBIT;
            end else
`endif
            begin
                errCodeNext = failCode;
                stateNext   = ERR;
            end
        end
    end

    assign oPs2_Clk_Oe  = (state == INHIBIT) || (state == RTS);
    assign oPs2_Data_Oe = dataOe;
    assign oBusy        = state inside {INHIBIT, RTS, SEND, ACK, WAIT_IDLE};
    assign oDone        = (state == DONE);
    assign oError       = (state == ERR);
    assign oErrCode     = errCode;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a wired-AND PS/2 line and a simple device model.
// Timing parameters are shortened so every frame completes in a few hundred cycles.
module tb_ps2_host_tx;

    localparam int INH     = 40;
    localparam int SETUP   = 10;
    localparam int TIMEOUT = 400;
    localparam int HALF    = 20;

    logic       clk = 1'b0;
    logic       rstN;
    logic       iStart;
    logic [7:0] iData;
    logic       devClkLow, devDataLow;
    logic       padClk, padData;
    logic       oPs2_Clk_Oe, oPs2_Data_Oe, oBusy, oDone, oError;
    logic [1:0] oErrCode;

    assign padClk  = ~(oPs2_Clk_Oe | devClkLow);
    assign padData = ~(oPs2_Data_Oe | devDataLow);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .SETUP_CYCLES  (SETUP),
        .TIMEOUT_CYCLES(TIMEOUT),
        .MAX_RETRIES   (2)
    ) dut (
        .iClk        (clk),
        .iReset_n    (rstN),
        .iStart      (iStart),
        .iData       (iData),
        .iPs2_Clk    (padClk),
        .iPs2_Data   (padData),
        .oPs2_Clk_Oe (oPs2_Clk_Oe),
        .oPs2_Data_Oe(oPs2_Data_Oe),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .oError      (oError),
        .oErrCode    (oErrCode)
    );

    int nChecks = 0;
    int nFail   = 0;

    // Running totals observed on the line; tests take deltas around each frame.
    int doneTot = 0, errTot = 0, inhTot = 0, rtsTot = 0, inhPhases = 0;
    logic inhPrev = 1'b0;
    logic [4:0] errSnap = '0;

    always @(negedge clk) begin
        if (oDone) doneTot++;
        if (oError) begin
            errTot++;
            errSnap = {oPs2_Clk_Oe, oPs2_Data_Oe, oBusy, oErrCode};
        end
        if (oPs2_Clk_Oe && !oPs2_Data_Oe) inhTot++;
        if (oPs2_Clk_Oe && oPs2_Data_Oe) rtsTot++;
        if (oPs2_Clk_Oe && !oPs2_Data_Oe && !inhPrev) inhPhases++;
        inhPrev = oPs2_Clk_Oe && !oPs2_Data_Oe;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic startFrame(input logic [7:0] d);
        @(negedge clk);
        iData  = d;
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
    endtask

    // Device model: waits for the host's request-to-send, then generates nFalls
    // clock pulses, sampling the data line just after each rising edge.
    task automatic devFrame(input logic ackLow, input int nFalls, output logic [10:0] got);
        int t;
        got = '0;
        t = 0;
        while (!(oPs2_Clk_Oe == 1'b0 && oPs2_Data_Oe == 1'b1) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("dev_wait_rts", 32'(t < 5000), 32'd1);
        repeat (10) @(negedge clk);
        for (int i = 0; i < nFalls; i++) begin
            got[i] = padData;
            if (i == 10) devDataLow = ackLow;
            repeat (HALF) @(negedge clk);
            devClkLow = 1'b1;
            repeat (HALF) @(negedge clk);
            devClkLow = 1'b0;
        end
        devDataLow = 1'b0;
    endtask

    task automatic waitIdle();
        int t;
        t = 0;
        while (oBusy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("idle_wait", 32'(oBusy), 32'd0);
        repeat (5) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       ackLow;
        logic       expParity;
        logic       expDone;
        logic [1:0] expCode;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [10:0] got;
        int d0, e0, i0, r0, p0, n, t;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b1, 2'b00};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b1, 2'b00};
        vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b1, 2'b00};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 2'b00};
        vecs[4] = '{8'hA5, 1'b0, 1'b1, 1'b0, 2'b01};
        vecs[5] = '{8'h3C, 1'b1, 1'b1, 1'b1, 2'b00};

        rstN = 1'b0; iStart = 1'b0; iData = 8'h00; devClkLow = 1'b0; devDataLow = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {26'd0, oPs2_Clk_Oe, oPs2_Data_Oe, oBusy, oDone, oError, 1'b0},
              32'd0);
        check("rst_errcode", 32'(oErrCode), 32'd0);
        rstN = 1'b1;
        repeat (3) @(negedge clk);

        // Table: parity sweep, ACK and NACK endings.
        for (int v = 0; v < 6; v++) begin
            d0 = doneTot; e0 = errTot; i0 = inhTot; r0 = rtsTot;
            startFrame(vecs[v].data);
            check("start_busy", 32'(oBusy), 32'd1);
            check("start_errcode_clear", 32'(oErrCode), 32'd0);
            devFrame(vecs[v].ackLow, 11, got);
            waitIdle();
            check("frame_bits", 32'(got), 32'({1'b1, vecs[v].expParity, vecs[v].data, 1'b0}));
            check("inhibit_len", 32'(inhTot - i0), 32'(INH));
            check("rts_len", 32'(rtsTot - r0), 32'(SETUP));
            check("done_count", 32'(doneTot - d0), 32'(vecs[v].expDone));
            check("error_count", 32'(errTot - e0), 32'(!vecs[v].expDone));
            check("errcode_held", 32'(oErrCode), 32'(vecs[v].expCode));
            if (!vecs[v].expDone)
                check("err_pulse_state", 32'(errSnap), 32'({3'b000, vecs[v].expCode}));
        end

        // Device never clocks: watchdog expiry measured from SEND entry.
        d0 = doneTot; e0 = errTot;
        startFrame(8'h12);
        t = 0;
        while (oPs2_Clk_Oe && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("to_reach_send", 32'(oPs2_Clk_Oe), 32'd0);
        n = 0;
        while (!oError && n < TIMEOUT + 50) begin
            @(negedge clk);
            n++;
        end
        check("to_latency", 32'(n), 32'(TIMEOUT));
        check("to_errcode", 32'(oErrCode), 32'd2);
        check("to_oe_busy", {29'd0, oPs2_Clk_Oe, oPs2_Data_Oe, oBusy}, 32'd0);
        waitIdle();
        check("to_no_done", 32'(doneTot - d0), 32'd0);
        check("to_one_error", 32'(errTot - e0), 32'd1);

        // iStart mid-frame must not disturb the byte in flight.
        d0 = doneTot; e0 = errTot;
        startFrame(8'h96);
        fork
            devFrame(1'b1, 11, got);
            begin
                t = 0;
                while (oPs2_Clk_Oe && t < 1000) begin
                    @(negedge clk);
                    t++;
                end
                repeat (100) @(negedge clk);
                iData  = 8'h55;
                iStart = 1'b1;
                @(negedge clk);
                iStart = 1'b0;
            end
        join
        waitIdle();
        check("busy_ignore_bits", 32'(got), 32'({1'b1, 1'b1, 8'h96, 1'b0}));
        check("busy_ignore_done", 32'(doneTot - d0), 32'd1);
        check("busy_ignore_noerr", 32'(errTot - e0), 32'd0);

        // Reset while data bit 4 of 0xED (a 0, so data is driven low) is on the line.
        d0 = doneTot; e0 = errTot;
        startFrame(8'hED);
        devFrame(1'b1, 5, got);
        repeat (2) @(negedge clk);
        check("rst_mid_bits", 32'(got[4:0]), 32'b11010);
        check("rst_mid_pre_oe", {30'd0, oPs2_Clk_Oe, oPs2_Data_Oe}, 32'b01);
        check("rst_mid_pre_busy", 32'(oBusy), 32'd1);
        #3 rstN = 1'b0;
        #1;
        check("rst_mid_oe", {30'd0, oPs2_Clk_Oe, oPs2_Data_Oe}, 32'd0);
        check("rst_mid_busy", 32'(oBusy), 32'd0);
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (30) @(negedge clk);
        check("rst_mid_no_pulses", 32'((doneTot - d0) + (errTot - e0)), 32'd0);

`ifdef PS2_TX_RETRY_EN
        // First attempt NACKed, retry ACKed: one oDone, no oError.
        d0 = doneTot; e0 = errTot; p0 = inhPhases;
        startFrame(8'h0F);
        devFrame(1'b0, 11, got);
        check("retry_busy_between", 32'(oBusy), 32'd1);
        devFrame(1'b1, 11, got);
        waitIdle();
        check("retry_bits", 32'(got), 32'({1'b1, 1'b1, 8'h0F, 1'b0}));
        check("retry_inhibit_phases", 32'(inhPhases - p0), 32'd2);
        check("retry_done", 32'(doneTot - d0), 32'd1);
        check("retry_noerr", 32'(errTot - e0), 32'd0);
`else
        p0 = inhPhases;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
